evu_trace_unit: RTL and testbench

- Parametrised successor of the single-mux event unit.
- Provides NUM_CH independently configured event channels. Each channel selects one of NUM_EVENTS core event lines and qualifies it by privilege level and optional ASID match.
- Hits in the same cycle are coalesced into one timestamped trace packet. Packets are buffered in a FIFO and drained to the SPU trace sink over a valid/ready handshake.
- Sits between the core event sources (cache/TLB misses, scoreboard full, exceptions, branch resolve) and the SPU interface. Configuration arrives from the AXI-lite register front-end.

---
 rtl/evu_trace_unit.sv | 188 ++++++++++++++++++
 tb/tb_evu_trace_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evu_trace_unit.sv
// Event trace unit: NUM_CH configurable channels select and qualify core event
// lines. Same-cycle hits are coalesced into one timestamped packet, buffered in
// a show-ahead FIFO and drained to the trace sink over valid/ready.
module evu_trace_unit #(
  parameter int NUM_CH     = 4,
  parameter int NUM_EVENTS = 16,
  parameter int ASID_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = 32,
  localparam int SEL_W     = $clog2(NUM_EVENTS),
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic [1:0]            priv_lvl_i,
  input  logic [ASID_W-1:0]     asid_i,
  input  logic                  cfg_we_i,
  input  logic [3:0]            cfg_ch_i,
  input  logic [31:0]           cfg_wdata_i,
  output logic [31:0]           cfg_rdata_o,
  output logic                  pkt_valid_o,
  input  logic                  pkt_ready_i,
  output logic [NUM_CH-1:0]     pkt_ch_mask_o,
  output logic [1:0]            pkt_priv_o,
  output logic [ASID_W-1:0]     pkt_asid_o,
  output logic [TS_W-1:0]       pkt_ts_o,
  output logic                  pkt_ovf_o,
  output logic [15:0]           drop_cnt_o,
  output logic [LVL_W-1:0]      fifo_level_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [NUM_CH-1:0] mask;
    logic [1:0]        priv;
    logic [ASID_W-1:0] asid;
    logic [TS_W-1:0]   ts;
    logic              ovf;
  } pkt_t;

  // Privilege qualifier: U/S/M allow bits, reserved level never qualifies.
  function automatic logic priv_ok(input logic [2:0] allow, input logic [1:0] priv);
    case (priv)
      2'b00:   return allow[0];
      2'b01:   return allow[1];
      2'b11:   return allow[2];
      default: return 1'b0;
    endcase
  endfunction

  // Drop counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [SEL_W-1:0]  cfg_sel     [NUM_CH];
  logic              cfg_en      [NUM_CH];
  logic [2:0]        cfg_allow   [NUM_CH];
  logic              cfg_asid_en [NUM_CH];
  logic [ASID_W-1:0] cfg_asid    [NUM_CH];

  logic [NUM_CH-1:0] hit_p0;
  logic              push_req_p0;
  logic              do_push, do_pop, do_drop, full;

  pkt_t              fifo_mem_p1 [FIFO_DEPTH];
  pkt_t              head_p1;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [TS_W-1:0]   ts_q;
  logic [15:0]       drop_cnt;
  logic              ovf_pending;

  // Channel configuration registers; out-of-range channel writes match nothing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cfg_sel[c]     <= '0;
        cfg_en[c]      <= 1'b0;
        cfg_allow[c]   <= '0;
        cfg_asid_en[c] <= 1'b0;
        cfg_asid[c]    <= '0;
      end
    end else if (cfg_we_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_ch_i == 4'(c)) begin
          cfg_sel[c]     <= cfg_wdata_i[SEL_W-1:0];
          cfg_en[c]      <= cfg_wdata_i[8];
          cfg_allow[c]   <= cfg_wdata_i[11:9];
          cfg_asid_en[c] <= cfg_wdata_i[12];
          cfg_asid[c]    <= cfg_wdata_i[16 +: ASID_W];
        end
      end
    end
  end

  // Combinational config read-back; unused bits and invalid channels read 0.
  always_comb begin
    cfg_rdata_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_ch_i == 4'(c)) begin
        cfg_rdata_o[SEL_W-1:0]     = cfg_sel[c];
        cfg_rdata_o[8]             = cfg_en[c];
        cfg_rdata_o[11:9]          = cfg_allow[c];
        cfg_rdata_o[12]            = cfg_asid_en[c];
        cfg_rdata_o[16 +: ASID_W]  = cfg_asid[c];
      end
    end
  end

  // Stage p0: per-channel hit qualification in the event cycle.
  always_comb begin
    hit_p0 = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      hit_p0[c] = cfg_en[c]
                & (int'(cfg_sel[c]) < NUM_EVENTS)
                & event_i[cfg_sel[c]]
                & priv_ok(cfg_allow[c], priv_lvl_i)
                & (~cfg_asid_en[c] | (asid_i == cfg_asid[c]));
    end
  end

  assign full        = (level == LVL_W'(FIFO_DEPTH));
  assign pkt_valid_o = (level != '0);
  assign push_req_p0 = (|hit_p0) & ~clear_i;
  assign do_pop      = pkt_valid_o & pkt_ready_i;
  assign do_push     = push_req_p0 & (~full | do_pop);
  assign do_drop     = push_req_p0 & full & ~do_pop;

  // FIFO pointers and occupancy; clear flushes, reset empties immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // Stage p1: packet storage, written only on an accepted push.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      fifo_mem_p1[wr_ptr] <= '{mask: hit_p0, priv: priv_lvl_i, asid: asid_i,
                               ts: ts_q, ovf: ovf_pending};
    end
  end

  // Free-running timestamp, drop counter and pending-overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_q        <= '0;
      drop_cnt    <= '0;
      ovf_pending <= 1'b0;
    end else if (clear_i) begin
      ts_q        <= '0;
      drop_cnt    <= '0;
      ovf_pending <= 1'b0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (do_drop) begin
        drop_cnt    <= sat_inc(drop_cnt);
        ovf_pending <= 1'b1;
      end else if (do_push) begin
        ovf_pending <= 1'b0;
      end
    end
  end

  assign head_p1       = fifo_mem_p1[rd_ptr];
  assign pkt_ch_mask_o = pkt_valid_o ? head_p1.mask : '0;
  assign pkt_priv_o    = pkt_valid_o ? head_p1.priv : '0;
  assign pkt_asid_o    = pkt_valid_o ? head_p1.asid : '0;
  assign pkt_ts_o      = pkt_valid_o ? head_p1.ts   : '0;
  assign pkt_ovf_o     = pkt_valid_o ? head_p1.ovf  : 1'b0;
  assign drop_cnt_o    = drop_cnt;
  assign fifo_level_o  = level;

endmodule

// File: tb/tb_evu_trace_unit.sv
// Bench for evu_trace_unit: directed tables, multi-cycle corner sequences and
// randomized traffic against a queue-based packet model.
module tb_evu_trace_unit;

  localparam logic [31:0] USED = 32'hFFFF_1F0F;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n, clear, cfg_we, ready;
  logic [15:0] ev, asid;
  logic [1:0]  priv;
  logic [3:0]  cfg_ch;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic        pkt_valid, pkt_ovf;
  logic [3:0]  pkt_mask, level;
  logic [1:0]  pkt_priv;
  logic [15:0] pkt_asid, drop_cnt;
  logic [31:0] pkt_ts;

  logic [31:0] t4_rdata;
  logic        t4_valid, t4_ovf;
  logic [3:0]  t4_mask, t4_level, t4_ts;
  logic [1:0]  t4_priv;
  logic [15:0] t4_asid, t4_drop;

  always #5 clk = ~clk;

  evu_trace_unit dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .event_i(ev),
    .priv_lvl_i(priv), .asid_i(asid), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
    .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata), .pkt_valid_o(pkt_valid),
    .pkt_ready_i(ready), .pkt_ch_mask_o(pkt_mask), .pkt_priv_o(pkt_priv),
    .pkt_asid_o(pkt_asid), .pkt_ts_o(pkt_ts), .pkt_ovf_o(pkt_ovf),
    .drop_cnt_o(drop_cnt), .fifo_level_o(level)
  );

  evu_trace_unit #(.TS_W(4)) dut_ts4 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .event_i(ev),
    .priv_lvl_i(priv), .asid_i(asid), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
    .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(t4_rdata), .pkt_valid_o(t4_valid),
    .pkt_ready_i(ready), .pkt_ch_mask_o(t4_mask), .pkt_priv_o(t4_priv),
    .pkt_asid_o(t4_asid), .pkt_ts_o(t4_ts), .pkt_ovf_o(t4_ovf),
    .drop_cnt_o(t4_drop), .fifo_level_o(t4_level)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [1:0]  priv;
    logic [15:0] asid;
    logic [31:0] ts;
    logic        ovf;
  } mpkt_t;

  typedef struct {
    logic [31:0] c0, c1, c2, c3;
    logic [1:0]  priv;
    logic [15:0] asid;
    logic [15:0] ev;
    logic [3:0]  exp_mask;
  } vec_t;

  mpkt_t       mq[$];
  logic [31:0] m_cfg [4];
  logic [31:0] m_ts;
  int          m_drop;
  logic        m_ovf;
  int          n_checks = 0;
  int          n_pass = 0;
  vec_t        vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] ch);
    return (ch < 4) ? m_cfg[ch] : 32'h0;
  endfunction

  // Channel hit rule evaluated from the raw config words.
  function automatic logic [3:0] m_hits(input logic [15:0] e, input logic [1:0] pv,
                                        input logic [15:0] as);
    logic [3:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      logic [31:0] w;
      int          sel;
      logic        pok;
      w   = m_cfg[c];
      sel = int'(w[7:0]);
      pok = (pv == 2'b00) ? w[9] : (pv == 2'b01) ? w[10] : (pv == 2'b11) ? w[11] : 1'b0;
      r[c] = w[8] && (sel < 16) && e[sel] && pok && (!w[12] || (w[31:16] == as));
    end
    return r;
  endfunction

  task automatic check_state();
    mpkt_t h;
    chk("valid", pkt_valid, mq.size() > 0);
    chk("level", level, mq.size());
    chk("drop_cnt", drop_cnt, m_drop);
    chk("cfg_rdata", cfg_rdata, m_read(cfg_ch));
    chk("t4_valid", t4_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      h = mq[0];
      chk("head_mask", pkt_mask, h.mask);
      chk("head_priv", pkt_priv, h.priv);
      chk("head_asid", pkt_asid, h.asid);
      chk("head_ts", pkt_ts, h.ts);
      chk("head_ovf", pkt_ovf, h.ovf);
      chk("t4_head_ts", t4_ts, h.ts[3:0]);
    end else begin
      chk("idle_fields", {pkt_ovf, pkt_priv, pkt_mask, pkt_asid}, 0);
      chk("idle_ts", pkt_ts, 0);
    end
  endtask

  // One clock: predict from pre-edge inputs, advance the model, then compare.
  task automatic tick();
    logic [3:0] h;
    bit         pop, preq;
    mpkt_t      p;
    h    = m_hits(ev, priv, asid);
    pop  = (mq.size() > 0) && ready;
    preq = (h != 0) && !clear;
    p.mask = h; p.priv = priv; p.asid = asid; p.ts = m_ts; p.ovf = m_ovf;
    @(posedge clk); #1;
    if (clear) begin
      mq.delete(); m_ts = 0; m_drop = 0; m_ovf = 0;
    end else begin
      m_ts++;
      if (pop) void'(mq.pop_front());
      if (preq) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(p); m_ovf = 0;
        end else begin
          if (m_drop < 65535) m_drop++;
          m_ovf = 1;
        end
      end
    end
    if (cfg_we && cfg_ch < 4) m_cfg[cfg_ch] = cfg_wdata & USED;
    check_state();
  endtask

  task automatic cfg_write(input logic [3:0] ch, input logic [31:0] w);
    cfg_we = 1'b1; cfg_ch = ch; cfg_wdata = w;
    tick();
    cfg_we = 1'b0; cfg_ch = 4'd0;
  endtask

  task automatic model_reset();
    mq.delete(); m_ts = 0; m_drop = 0; m_ovf = 0;
    for (int c = 0; c < 4; c++) m_cfg[c] = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; cfg_we = 1'b0; ready = 1'b0;
    ev = '0; asid = '0; priv = '0; cfg_ch = '0; cfg_wdata = '0;
    model_reset();

    vecs[0] = '{32'h0000_0301, 32'h0000_0901, 32'h0005_1F01, 32'h0, 2'b11, 16'h0005, 16'h0002, 4'b0110};
    vecs[1] = '{32'h0000_0301, 32'h0000_0901, 32'h0005_1F01, 32'h0, 2'b10, 16'h0005, 16'h0002, 4'b0000};
    vecs[2] = '{32'h0000_0301, 32'h0000_0901, 32'h0005_1F01, 32'h0, 2'b00, 16'h0005, 16'h0002, 4'b0101};
    vecs[3] = '{32'h0000_0301, 32'h0000_0901, 32'h0005_1F01, 32'h0, 2'b11, 16'h0006, 16'h0002, 4'b0010};
    vecs[4] = '{32'h0000_0E02, 32'h0000_0F02, 32'h0000_0F0E, 32'h0000_0F02, 2'b01, 16'h0000, 16'h0004, 4'b1010};
    vecs[5] = '{32'h0000_0F0F, 32'h0, 32'h0, 32'h0000_0FFF, 2'b00, 16'h0000, 16'h8000, 4'b1001};

    repeat (3) @(posedge clk);
    #1;
    check_state();
    rst_n = 1'b1;

    // Basic hit at timestamp 10, popped the cycle after.
    cfg_write(4'd0, 32'h0000_0F03);
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (10) tick();
    ready = 1'b1; ev = 16'h0008;
    tick();
    ev = '0;
    chk("basic_valid", pkt_valid, 1);
    chk("basic_mask", pkt_mask, 4'b0001);
    chk("basic_ts", pkt_ts, 10);
    tick();
    chk("basic_popped", pkt_valid, 0);

    // Coalescing and qualification table.
    for (int i = 0; i < 6; i++) begin
      cfg_write(4'd0, vecs[i].c0);
      cfg_write(4'd1, vecs[i].c1);
      cfg_write(4'd2, vecs[i].c2);
      cfg_write(4'd3, vecs[i].c3);
      priv = vecs[i].priv; asid = vecs[i].asid; ev = vecs[i].ev;
      tick();
      ev = '0;
      chk($sformatf("vec%0d_valid", i), pkt_valid, vecs[i].exp_mask != 0);
      chk($sformatf("vec%0d_mask", i), pkt_mask, vecs[i].exp_mask);
      tick();
    end

    // Overflow: 10 hits into 8 entries with the sink stalled.
    cfg_write(4'd0, 32'h0000_0F03);
    for (int c = 1; c < 4; c++) cfg_write(4'(c), 32'h0);
    priv = 2'b00; asid = '0;
    clear = 1'b1; tick(); clear = 1'b0;
    ready = 1'b0; ev = 16'h0008;
    repeat (10) tick();
    ev = '0;
    chk("ovf_level", level, 8);
    chk("ovf_drop", drop_cnt, 2);
    ready = 1'b1;
    repeat (8) tick();
    chk("ovf_drained", pkt_valid, 0);
    ev = 16'h0008;
    tick();
    chk("ovf_first_flag", pkt_ovf, 1);
    tick();
    chk("ovf_second_flag", pkt_ovf, 0);
    ev = '0;
    tick();

    // Full FIFO with simultaneous push and pop.
    ready = 1'b0; ev = 16'h0008;
    repeat (8) tick();
    chk("fullpp_fill", level, 8);
    ready = 1'b1;
    tick();
    chk("fullpp_level", level, 8);
    chk("fullpp_drop", drop_cnt, 2);
    ev = '0;
    repeat (8) tick();

    // Backpressure hold, then clear.
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      asid = 16'h0010 + 16'(i); ev = 16'h0008;
      tick();
    end
    ev = '0; asid = '0;
    repeat (5) tick();
    chk("bp_level", level, 3);
    chk("bp_head_asid", pkt_asid, 16'h0010);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_valid", pkt_valid, 0);
    chk("clr_level", level, 0);
    chk("clr_drop", drop_cnt, 0);
    cfg_ch = 4'd0; #1;
    chk("clr_cfg_kept", cfg_rdata, 32'h0000_0F03);

    // Out-of-range config channel.
    cfg_write(4'd4, 32'hFFFF_FFFF);
    cfg_ch = 4'd4; #1;
    chk("oob_read", cfg_rdata, 0);
    for (int c = 0; c < 4; c++) begin
      cfg_ch = 4'(c); #1;
      chk($sformatf("oob_ch%0d", c), cfg_rdata, (c == 0) ? 32'h0000_0F03 : 32'h0);
    end
    cfg_ch = 4'd0;

    // Asynchronous reset with the FIFO half full.
    ready = 1'b0; ev = 16'h0008;
    repeat (4) tick();
    ev = '0;
    chk("rst_pre_level", level, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", pkt_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_mask", pkt_mask, 0);
    chk("rst_ts", pkt_ts, 0);
    chk("rst_cfg", cfg_rdata, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ev = 16'h0008;
    tick();
    ev = '0;

    // Timestamp wrap on the 4-bit instance.
    cfg_write(4'd0, 32'h0000_0F03);
    ready = 1'b1;
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (16) tick();
    ev = 16'h0008;
    tick();
    ev = '0;
    chk("wrap_t4_ts", t4_ts, 0);
    chk("wrap_ts", pkt_ts, 16);
    tick();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cfg_we    = ($urandom % 8) == 0;
      cfg_ch    = 4'($urandom % 6);
      cfg_wdata = {16'($urandom % 4), 3'b000, 13'($urandom)};
      ev        = 16'($urandom) & 16'($urandom) & 16'($urandom);
      priv      = 2'($urandom % 4);
      asid      = 16'($urandom % 4);
      ready     = (i < 200) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
      clear     = ($urandom % 60) == 0;
      tick();
    end
    cfg_we = 1'b0; clear = 1'b0; ev = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
